// File: rtl/alu.sv
// Registered 4-function-class ALU with one-cycle latency and a single-cycle out_valid strobe.
// Define ALU_FLAGS_EN to add the carry/zero/negative/overflow status flag ports and registers.
module alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
`ifdef ALU_FLAGS_EN
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
`endif
  output logic             out_valid
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] res_s;

  // Extra MSB of sum/diff carries the carry-out / borrow.
  assign sum_s  = {1'b0, A} + {1'b0, B};
  assign diff_s = {1'b0, A} - {1'b0, B};

  // Operation result selection.
  always_comb begin
    res_s = {WIDTH{1'b0}};
    case (op)
      OP_ADD:  res_s = sum_s[WIDTH-1:0];
      OP_SUB:  res_s = diff_s[WIDTH-1:0];
      OP_AND:  res_s = A & B;
      OP_OR:   res_s = A | B;
      OP_XOR:  res_s = A ^ B;
      OP_NOT:  res_s = ~A;
      OP_SHL:  res_s = {A[WIDTH-2:0], 1'b0};
      OP_SHR:  res_s = {1'b0, A[WIDTH-1:1]};
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  // Result and valid strobe; result holds whenever in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= {WIDTH{1'b0}};
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= res_s;
      end else begin
        result <= result;
      end
    end
  end

`ifdef ALU_FLAGS_EN
  logic carry_s;
  logic overflow_s;

  // Carry/borrow and signed-overflow per operation; logic ops clear both.
  always_comb begin
    carry_s    = 1'b0;
    overflow_s = 1'b0;
    case (op)
      OP_ADD: begin
        carry_s    = sum_s[WIDTH];
        overflow_s = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        carry_s    = diff_s[WIDTH];
        overflow_s = (A[WIDTH-1] != B[WIDTH-1]) && (diff_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SHL:  carry_s = A[WIDTH-1];
      OP_SHR:  carry_s = A[0];
      default: begin
        carry_s    = 1'b0;
        overflow_s = 1'b0;
      end
    endcase
  end

  // Status flag registers, updated together with result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry    <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else if (in_valid) begin
      carry    <= carry_s;
      zero     <= (res_s == {WIDTH{1'b0}});
      negative <= res_s[WIDTH-1];
      overflow <= overflow_s;
    end else begin
      carry    <= carry;
      zero     <= zero;
      negative <= negative;
      overflow <= overflow;
    end
  end
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu (WIDTH=4); flag checks compile in with ALU_FLAGS_EN.
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [3:0] a_s;
  logic [3:0] b_s;
  logic [2:0] op_s;
  logic       in_valid;
  logic [3:0] result;
  logic       out_valid;
`ifdef ALU_FLAGS_EN
  logic       carry, zero, negative, overflow;
`endif

  int n_checks;
  int n_fails;

  alu #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (a_s),
    .B        (b_s),
    .op       (op_s),
    .in_valid (in_valid),
    .result   (result),
`ifdef ALU_FLAGS_EN
    .carry    (carry),
    .zero     (zero),
    .negative (negative),
    .overflow (overflow),
`endif
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // flg packs {carry, zero, negative, overflow}
  task automatic check_out(input string tag, input logic [3:0] res, input logic [3:0] flg);
    check_eq({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, ".result"}, {28'd0, result}, {28'd0, res});
`ifdef ALU_FLAGS_EN
    check_eq({tag, ".flags"}, {28'd0, carry, zero, negative, overflow}, {28'd0, flg});
`else
    if (flg === 4'bxxxx) $display("unused flags");
`endif
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] o, input logic [3:0] res, input logic [3:0] flg);
    @(negedge clk);
    a_s = a; b_s = b; op_s = o; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_out(tag, res, flg);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, ".result"}, {28'd0, result}, 32'd0);
`ifdef ALU_FLAGS_EN
    check_eq({tag, ".flags"}, {28'd0, carry, zero, negative, overflow}, 32'd0);
`endif
  endtask

  logic [3:0] sw_res [8];
  logic [3:0] sw_flg [8];

  initial begin
    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0;
    a_s = 4'd0; b_s = 4'd0; op_s = 3'd0;
    n_checks = 0; n_fails = 0;

    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle.valid", {31'd0, out_valid}, 32'd0);

    //      tag        A        B        op      result   {c,z,n,v}
    run_op("add_basic", 4'b0010, 4'b0001, 3'b000, 4'b0011, 4'b0000);
    run_op("and_neg",   4'b1010, 4'b1100, 3'b010, 4'b1000, 4'b0010);
    run_op("add_wrap",  4'b1111, 4'b0001, 3'b000, 4'b0000, 4'b1100);
    run_op("add_ovf",   4'b0111, 4'b0001, 3'b000, 4'b1000, 4'b0011);
    run_op("sub_brw",   4'b0011, 4'b0101, 3'b001, 4'b1110, 4'b1010);
    run_op("shl",       4'b1001, 4'b0000, 3'b110, 4'b0010, 4'b1000);
    run_op("shr",       4'b1001, 4'b0000, 3'b111, 4'b0100, 4'b1000);
    run_op("or",        4'b0101, 4'b0010, 3'b011, 4'b0111, 4'b0000);
    run_op("xor",       4'b1100, 4'b1010, 3'b100, 4'b0110, 4'b0000);
    run_op("not",       4'b0101, 4'b1111, 3'b101, 4'b1010, 4'b0010);
    run_op("sub_ovf",   4'b1000, 4'b0001, 3'b001, 4'b0111, 4'b0001);
    run_op("sub_zero",  4'b0110, 4'b0110, 3'b001, 4'b0000, 4'b0100);

    // Back-to-back sweep of all opcodes with A=1011, B=0110
    sw_res[0] = 4'b0001; sw_flg[0] = 4'b1000;
    sw_res[1] = 4'b0101; sw_flg[1] = 4'b0001;
    sw_res[2] = 4'b0010; sw_flg[2] = 4'b0000;
    sw_res[3] = 4'b1111; sw_flg[3] = 4'b0010;
    sw_res[4] = 4'b1101; sw_flg[4] = 4'b0010;
    sw_res[5] = 4'b0100; sw_flg[5] = 4'b0000;
    sw_res[6] = 4'b0110; sw_flg[6] = 4'b1000;
    sw_res[7] = 4'b0101; sw_flg[7] = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("sweep%0d", i), 4'b1011, 4'b0110, 3'(i), sw_res[i], sw_flg[i]);
    end

    // Idle with changing inputs: valid drops, result and flags hold
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b0; a_s = 4'(i + 3); b_s = 4'b1111; op_s = 3'(i);
      @(posedge clk); #1;
      check_eq($sformatf("hold%0d.valid", i), {31'd0, out_valid}, 32'd0);
      check_eq($sformatf("hold%0d.result", i), {28'd0, result}, 32'd5);
`ifdef ALU_FLAGS_EN
      check_eq($sformatf("hold%0d.flags", i), {28'd0, carry, zero, negative, overflow}, 32'h8);
`endif
    end

    // Produce a nonzero output, then reset mid-period with an operation pending
    run_op("pre_rst", 4'b1111, 4'b0000, 3'b011, 4'b1111, 4'b0010);
    @(negedge clk);
    a_s = 4'b0111; b_s = 4'b0111; op_s = 3'b000; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    check_reset_outputs("rst_held");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("post_rst");
    run_op("recover", 4'b0100, 4'b0011, 3'b000, 4'b0111, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
